pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle MIPS datapath; successor to the fixed 32-bit PC. It holds the fetch address and selects the next PC from sequential, branch, jump, jump-register, return and exception sources. It also adds stall, an exception PC (EPC) register and an optional return-address stack (RAS). It sits between the control unit/ALU zero flag and instruction memory.

---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 65 ++++++
 rtl/pc_unit.sv | 126 ++++++++++++
 tb/tb_pc_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// Holds the next-PC source select enum and the fixed increment / jump-index widths.
// Imported by pc_unit; pc_ras is type-agnostic and needs nothing from here.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_RET,
    SEL_EXC,
    SEL_HOLD
  } next_sel_e;

  localparam int PC_INC = 4;
  localparam int JIDX_W = 26;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
// Latency: push/pop take effect on the next clk edge; top/empty/full are combinational from state.
// Backpressure: none; pop on empty is ignored, pop+push in one cycle replaces the top entry.
// Ports: clk, reset (async active-low), push, pop, push_dat[W], top[W], empty, full.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;   // next free slot; wraps naturally since DEPTH is a power of two
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_idx;
  logic          pop_ok;

  assign top_idx = ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (pop_ok && push) begin
      // pop then push lands in the same slot; pointer and count stay put
      mem_d[top_idx] = push_dat;
    end else if (push) begin
      // when full, ptr_q already points at the oldest entry, so this overwrites it
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + PW'(1);
      if (!full) cnt_d = cnt_q + CW'(1);
    end else if (pop_ok) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with exception, stall, branch, jump, jr and return selection.
// Latency: addr/epc register on the rising clk edge (1 cycle); pc_plus4 is combinational from addr.
// Backpressure: stall holds addr, epc and the return stack; exc overrides stall.
// Ports: clk, reset (async active-low), instruction[31:0], stall, branch, zero, jump, link,
//   jump_reg, ret, rs_data[ADDR_W], exc -> addr[ADDR_W], pc_plus4[ADDR_W], epc[ADDR_W].
// Option: define PC_RAS_EN to add a RAS_DEPTH-entry return-address stack (link pushes, ret pops).
module pc_unit
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              link,
  input  logic              jump_reg,
  input  logic              ret,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              exc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  next_sel_e         sel;

  logic [31:0]       pc4_ext;
  logic [31:0]       j_full;
  logic [31:0]       br_off_full;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] ret_target;
  logic              unused_bits;

  assign pc_plus4 = addr_q + ADDR_W'(PC_INC);
  assign addr     = addr_q;
  assign epc      = epc_q;

  // Targets are formed at 32 bits and truncated, so ADDR_W == 28 drops the region field cleanly.
  assign pc4_ext     = 32'(pc_plus4);
  assign j_full      = {pc4_ext[31:28], instruction[JIDX_W-1:0], 2'b00};
  assign j_target    = j_full[ADDR_W-1:0];
  assign br_off_full = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign br_target   = pc_plus4 + br_off_full[ADDR_W-1:0];
  assign jr_target   = {rs_data[ADDR_W-1:2], 2'b00};
  assign unused_bits = ^{instruction[31:JIDX_W], rs_data[1:0]};

`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              unused_ras;

  // Stack changes are suppressed while stalled or excepting so a retried instruction does not double-push.
  assign ras_push   = link && !stall && !exc;
  assign ras_pop    = ret && !stall && !exc;
  assign ret_target = ras_empty ? jr_target : ras_top;
  assign unused_ras = ras_full;

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_dat (pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );
`else
  assign ret_target = jr_target;
`endif

  // Priority chain: jump is tested before branch, so branch/zero never matter when jump is set.
  always_comb begin
    sel    = SEL_SEQ;
    addr_d = pc_plus4;
    epc_d  = epc_q;
    if (exc)                 sel = SEL_EXC;
    else if (stall)          sel = SEL_HOLD;
    else if (ret)            sel = SEL_RET;
    else if (jump_reg)       sel = SEL_JR;
    else if (jump || link)   sel = SEL_J;
    else if (branch && zero) sel = SEL_BR;
    else                     sel = SEL_SEQ;

    case (sel)
      SEL_EXC: begin
        addr_d = EXC_VECTOR[ADDR_W-1:0];
        epc_d  = addr_q;
      end
      SEL_HOLD: addr_d = addr_q;
      SEL_RET:  addr_d = ret_target;
      SEL_JR:   addr_d = jr_target;
      SEL_J:    addr_d = j_target;
      SEL_BR:   addr_d = br_target;
      default:  addr_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= RESET_ADDR[ADDR_W-1:0];
      epc_q  <= '0;
    end else begin
      addr_q <= addr_d;
      epc_q  <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit with a behavioural reference model.
// Expected addr/epc are queued when inputs are driven and compared one edge later.
// Exercises reset, branch, jump, stall, exception, jr/ret and (with PC_RAS_EN) the return stack.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        stall, branch, zero, jump, link, jump_reg, ret, exc;
  logic [31:0] rs_data;
  logic [31:0] addr, pc_plus4, epc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_addr, m_epc;
  logic [63:0] exp_q[$];
`ifdef PC_RAS_EN
  logic [31:0] m_ras[$];
`endif

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W     (32),
    .RESET_ADDR (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0080),
    .RAS_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .link        (link),
    .jump_reg    (jump_reg),
    .ret         (ret),
    .rs_data     (rs_data),
    .exc         (exc),
    .addr        (addr),
    .pc_plus4    (pc_plus4),
    .epc         (epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instruction = 32'h0; stall = 0; branch = 0; zero = 0; jump = 0;
    link = 0; jump_reg = 0; ret = 0; rs_data = 32'h0; exc = 0;
  endtask

  task automatic model_reset();
    m_addr = 32'h0;
    m_epc  = 32'h0;
`ifdef PC_RAS_EN
    m_ras.delete();
`endif
  endtask

  // Evaluate the reference model on the current inputs, queue the result, clock once, compare.
  task automatic cycle(input string tag);
    logic [31:0] pc4, nxt, nepc, jrt;
    logic [63:0] e;
    pc4  = m_addr + 32'd4;
    nxt  = pc4;
    nepc = m_epc;
    jrt  = {rs_data[31:2], 2'b00};
    if (exc) begin
      nxt  = 32'h0000_0080;
      nepc = m_addr;
    end else if (stall) begin
      nxt = m_addr;
    end else begin
      if (ret) begin
`ifdef PC_RAS_EN
        if (m_ras.size() > 0) nxt = m_ras.pop_back();
        else                  nxt = jrt;
`else
        nxt = jrt;
`endif
      end else if (jump_reg) nxt = jrt;
      else if (jump || link) nxt = {pc4[31:28], instruction[25:0], 2'b00};
      else if (branch && zero) nxt = pc4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
`ifdef PC_RAS_EN
      if (link) begin
        m_ras.push_back(pc4);
        if (m_ras.size() > 4) m_ras.delete(0);
      end
`endif
    end
    m_addr = nxt;
    m_epc  = nepc;
    exp_q.push_back({nxt, nepc});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_addr"}, addr, e[63:32]);
      check({tag, "_epc"}, epc, e[31:0]);
      check({tag, "_pc4"}, pc_plus4, e[63:32] + 32'd4);
    end
  endtask

  logic [31:0] lifo_exp [5];

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_addr", addr, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_epc", epc, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_addr", addr, 32'h0);
    reset = 1'b1;

    cycle("seq1");
    check("seq1_const", addr, 32'h4);
    cycle("seq2");
    check("seq2_const", addr, 32'h8);
    check("seq2_pc4_const", pc_plus4, 32'hC);

    branch = 1; zero = 1; instruction = 32'h0000_1000;
    cycle("br_taken");
    check("br_taken_const", addr, 32'h400C);

    branch = 1'bx; zero = 1'bx; jump = 1; instruction = 32'h0008_0000;
    cycle("jump");
    check("jump_const", addr, 32'h0020_0000);
    idle_inputs();

    stall = 1;
    for (int i = 0; i < 3; i++) cycle("stall");
    check("stall_const", addr, 32'h0020_0000);
    exc = 1;
    cycle("exc_stall");
    check("exc_addr_const", addr, 32'h80);
    check("exc_epc_const", epc, 32'h0020_0000);
    idle_inputs();

    branch = 1; zero = 0; instruction = 32'h0000_1000;
    cycle("br_nt");
    check("br_nt_const", addr, 32'h84);
    idle_inputs();

    jump_reg = 1; rs_data = 32'h0000_0103;
    cycle("jr_misalign");
    check("jr_const", addr, 32'h100);
    idle_inputs();

    link = 1; instruction = 32'h0008_0000;
    cycle("link");
    check("link_const", addr, 32'h0020_0000);
    idle_inputs();
    ret = 1; rs_data = 32'hDEAD_BEEF;
    cycle("ret1");
`ifdef PC_RAS_EN
    check("ret1_const", addr, 32'h104);
`else
    check("ret1_const", addr, 32'hDEAD_BEEC);
`endif
    cycle("ret2");
    check("ret2_const", addr, 32'hDEAD_BEEC);
    idle_inputs();

    // five links then five rets from a clean region
    jump_reg = 1; rs_data = 32'h0;
    cycle("jr_zero");
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      link = 1; instruction = 32'h400 * (k + 1);
      cycle("link5");
    end
    idle_inputs();
    lifo_exp[0] = 32'h4004; lifo_exp[1] = 32'h3004; lifo_exp[2] = 32'h2004;
    lifo_exp[3] = 32'h1004; lifo_exp[4] = 32'h1234_5678;
    ret = 1; rs_data = 32'h1234_567B;
    for (int k = 0; k < 5; k++) begin
      cycle("ret5");
`ifdef PC_RAS_EN
      check("ret5_const", addr, lifo_exp[k]);
`else
      check("ret5_const", addr, 32'h1234_5678);
`endif
    end
    idle_inputs();

    // async reset mid-sequence clears state and the stack
    link = 1; instruction = 32'h400;
    cycle("link_pre_rst");
    cycle("link_pre_rst");
    idle_inputs();
    reset = 1'b0;
    #2;
    check("async_rst_addr", addr, 32'h0);
    check("async_rst_epc", epc, 32'h0);
    model_reset();
    reset = 1'b1;
    ret = 1; rs_data = 32'h1234_567B;
    cycle("ret_after_rst");
    check("ret_after_rst_const", addr, 32'h1234_5678);
    idle_inputs();

    // link and ret together: pop then push
    link = 1; instruction = 32'h800;
    cycle("link_a");
    link = 1; ret = 1; instruction = 32'h1000; rs_data = 32'h40;
    cycle("link_ret");
    ret = 1; link = 0;
    cycle("ret_after_lr");
    idle_inputs();

    for (int i = 0; i < 400; i++) begin
      instruction = $urandom();
      rs_data     = $urandom();
      exc         = ($urandom_range(0, 31) == 0);
      stall       = ($urandom_range(0, 7) == 0);
      ret         = ($urandom_range(0, 7) == 0);
      jump_reg    = ($urandom_range(0, 15) == 0);
      jump        = ($urandom_range(0, 15) == 0);
      link        = ($urandom_range(0, 9) == 0);
      branch      = ($urandom_range(0, 3) == 0);
      zero        = ($urandom_range(0, 1) == 0);
      cycle("rand");
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
